// File: rtl/ct_stream_feeder.sv
// ============================================================================
// Module  : ct_stream_feeder
// Brief   : Buffers a full score vector and streams it LANES elements per beat
//           to the comparison tree, with a one-deep shadow for gapless reload.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ct_stream_feeder #(
  parameter int DWT      = 8,
  parameter int LANES    = 2,
  parameter int NUM_ELEM = 16,
  parameter int BEAT_W   = 3,
  parameter int VCNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DWT*NUM_ELEM-1:0] load_data,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [DWT*LANES-1:0]    op_out,
  output logic                    op_first,
  output logic                    op_last,
  output logic [BEAT_W-1:0]       beat_idx,
  output logic                    done,
  output logic [VCNT_W-1:0]       vec_cnt
);

  localparam int                c_nbeats    = NUM_ELEM / LANES;
  localparam int                c_beat_bits = DWT * LANES;
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(c_nbeats - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                  r_state;
  logic [DWT*NUM_ELEM-1:0] r_active;
  logic [DWT*NUM_ELEM-1:0] r_shadow;
  logic                    r_shadow_full;
  logic [BEAT_W-1:0]       r_beat;
  logic                    r_done;
  logic [VCNT_W-1:0]       r_vec_cnt;

  logic                    w_load_ready;
  logic                    w_op_valid;
  logic                    w_load_fire;
  logic                    w_op_fire;
  logic                    w_last;
  logic [c_beat_bits-1:0]  w_beat_data;

  // load_ready looks only at registered state so a load never races a
  // shadow-to-active copy; arst_n gating keeps it low while reset is held.
  assign w_load_ready = en & arst_n &
                        ((r_state == ST_IDLE) | ((r_state == ST_STREAM) & ~r_shadow_full));
  assign w_op_valid   = en & arst_n & (r_state == ST_STREAM);
  assign w_load_fire  = w_load_ready & load_valid;
  assign w_op_fire    = w_op_valid & op_ready;
  assign w_last       = (r_beat == c_last_beat);

  always_comb begin
    w_beat_data = '0;
    for (int b = 0; b < c_nbeats; b++) begin
      if (r_beat == BEAT_W'(b)) begin
        w_beat_data = r_active[b*c_beat_bits +: c_beat_bits];
      end
    end
  end

  assign load_ready = w_load_ready;
  assign op_valid   = w_op_valid;
  assign op_out     = w_op_valid ? w_beat_data : '0;
  assign op_first   = w_op_valid & (r_beat == '0);
  assign op_last    = w_op_valid & w_last;
  assign beat_idx   = r_beat;
  assign done       = r_done;
  assign vec_cnt    = r_vec_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= ST_IDLE;
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_beat        <= '0;
      r_done        <= 1'b0;
      r_vec_cnt     <= '0;
    end else if (en) begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load_fire) begin
            r_active <= load_data;
            r_beat   <= '0;
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_load_fire && !(w_op_fire && w_last)) begin
            r_shadow      <= load_data;
            r_shadow_full <= 1'b1;
          end
          if (w_op_fire) begin
            if (!w_last) begin
              r_beat <= r_beat + BEAT_W'(1);
            end else begin
              r_done    <= 1'b1;
              r_vec_cnt <= r_vec_cnt + VCNT_W'(1);
              r_beat    <= '0;
              // Shadow wins; a same-cycle load is only possible with it empty.
              if (r_shadow_full) begin
                r_active      <= r_shadow;
                r_shadow_full <= 1'b0;
              end else if (w_load_fire) begin
                r_active <= load_data;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ct_stream_feeder.sv
// ============================================================================
// Module  : tb_ct_stream_feeder
// Brief   : Self-checking bench for ct_stream_feeder (vector table, directed
//           corner sequences, randomized run against a queue-based model).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ct_stream_feeder;

  localparam int DWT   = 8;
  localparam int LANES = 2;
  localparam int NE    = 16;
  localparam int NB    = NE / LANES;
  localparam int VW    = DWT * NE;
  localparam int OW    = DWT * LANES;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          en;
  logic          lv;
  logic          ordy;
  logic [VW-1:0] ld;
  logic          load_ready;
  logic          op_valid;
  logic [OW-1:0] op_out;
  logic          op_first;
  logic          op_last;
  logic [2:0]    beat_idx;
  logic          done;
  logic [7:0]    vec_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a vector queue holding at most two vectors (streaming + waiting).
  logic [VW-1:0] mq[$];
  int            mbeat;
  bit            mdone;
  int            mcnt;

  logic [VW-1:0] vec_a;
  logic [VW-1:0] vec_b;

  typedef struct {
    logic          en;
    logic          lv;
    logic          rdy;
    logic          e_valid;
    logic [OW-1:0] e_out;
    logic          e_first;
    logic          e_last;
    logic          e_lready;
    logic          e_done;
    logic [7:0]    e_cnt;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  ct_stream_feeder #(
    .DWT(DWT), .LANES(LANES), .NUM_ELEM(NE), .BEAT_W(3), .VCNT_W(8)
  ) dut (
    .clk(clk), .arst_n(arst_n), .en(en),
    .load_valid(lv), .load_ready(load_ready), .load_data(ld),
    .op_valid(op_valid), .op_ready(ordy), .op_out(op_out),
    .op_first(op_first), .op_last(op_last), .beat_idx(beat_idx),
    .done(done), .vec_cnt(vec_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbeat = 0;
    mdone = 0;
    mcnt  = 0;
  endtask

  task automatic check_model();
    logic          ev;
    logic [VW-1:0] cur;
    logic [OW-1:0] eo;
    ev  = en && arst_n && (mq.size() > 0);
    cur = (mq.size() > 0) ? mq[0] : '0;
    eo  = ev ? cur[mbeat*OW +: OW] : '0;
    chk("m_op_valid",   32'(op_valid),   32'(ev));
    chk("m_load_ready", 32'(load_ready), 32'(en && arst_n && (mq.size() < 2)));
    chk("m_op_out",     32'(op_out),     32'(eo));
    chk("m_op_first",   32'(op_first),   32'(ev && mbeat == 0));
    chk("m_op_last",    32'(op_last),    32'(ev && mbeat == NB - 1));
    chk("m_beat_idx",   32'(beat_idx),   32'(mbeat));
    chk("m_done",       32'(done),       32'(mdone));
    chk("m_vec_cnt",    32'(vec_cnt),    32'(mcnt));
  endtask

  task automatic model_edge();
    bit lfire, ofire;
    if (!arst_n) begin
      model_reset();
      return;
    end
    if (!en) return;
    lfire = lv && (mq.size() < 2);
    ofire = ordy && (mq.size() > 0);
    mdone = ofire && (mbeat == NB - 1);
    if (ofire) begin
      if (mbeat == NB - 1) begin
        void'(mq.pop_front());
        mbeat = 0;
        mcnt  = (mcnt + 1) % 256;
      end else begin
        mbeat++;
      end
    end
    if (lfire) mq.push_back(ld);
  endtask

  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rst_pulse();
    arst_n = 1'b0;
    lv     = 1'b0;
    model_reset();
    #1 check_model();
    @(posedge clk);
    #1 arst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NE; i++) begin
      vec_a[i*DWT +: DWT] = 8'(i + 1);
      vec_b[i*DWT +: DWT] = 8'(8'h81 + i);
    end
    // Single vector streamed with the sink always ready.
    tbl[0] = '{1, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 8'd0};
    for (int k = 0; k < NB; k++) begin
      tbl[1+k] = '{1, 0, 1, 1, {8'(2*k + 2), 8'(2*k + 1)}, (k == 0), (k == NB - 1), 1, 0, 8'd0};
    end
    tbl[9]  = '{1, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 8'd1};
    tbl[10] = '{1, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 8'd1};

    arst_n = 1'b0; en = 1'b0; lv = 1'b0; ordy = 1'b0; ld = '0;
    model_reset();
    #2 chk("reset_op_valid", 32'(op_valid), 0);
    chk("reset_load_ready", 32'(load_ready), 0);
    chk("reset_op_out", 32'(op_out), 0);
    rst_pulse();

    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en; lv = tbl[i].lv; ordy = tbl[i].rdy; ld = vec_a;
      #1;
      chk($sformatf("t%0d_op_valid", i),   32'(op_valid),   32'(tbl[i].e_valid));
      chk($sformatf("t%0d_op_out", i),     32'(op_out),     32'(tbl[i].e_out));
      chk($sformatf("t%0d_op_first", i),   32'(op_first),   32'(tbl[i].e_first));
      chk($sformatf("t%0d_op_last", i),    32'(op_last),    32'(tbl[i].e_last));
      chk($sformatf("t%0d_load_ready", i), 32'(load_ready), 32'(tbl[i].e_lready));
      chk($sformatf("t%0d_done", i),       32'(done),       32'(tbl[i].e_done));
      chk($sformatf("t%0d_vec_cnt", i),    32'(vec_cnt),    32'(tbl[i].e_cnt));
      tick();
    end

    // Back-to-back A then B via the shadow buffer.
    rst_pulse();
    en = 1; ordy = 1; lv = 1; ld = vec_a; tick();
    lv = 0; tick(); tick();
    lv = 1; ld = vec_b; tick();
    lv = 0;
    chk("ab_load_ready_shadow_full", 32'(load_ready), 0);
    repeat (4) tick();
    chk("ab_a_beat7", 32'(op_out), 32'h100F);
    tick();
    chk("ab_b_beat0", 32'(op_out), 32'h8281);
    chk("ab_b_first", 32'(op_first), 1);
    chk("ab_load_ready_back", 32'(load_ready), 1);
    repeat (8) tick();
    chk("ab_done", 32'(done), 1);
    chk("ab_vec_cnt", 32'(vec_cnt), 2);

    // Sink stall at beat 3.
    rst_pulse();
    en = 1; ordy = 1; lv = 1; ld = vec_a; tick();
    lv = 0; repeat (3) tick();
    ordy = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_op_out", 32'(op_out), 32'h0807);
      chk("stall_beat_idx", 32'(beat_idx), 3);
    end
    ordy = 1; repeat (5) tick();
    chk("stall_done", 32'(done), 1);
    chk("stall_vec_cnt", 32'(vec_cnt), 1);

    // Enable dropped at beat 5.
    rst_pulse();
    en = 1; ordy = 1; lv = 1; ld = vec_a; tick();
    lv = 0; repeat (5) tick();
    en = 0; #1;
    chk("en0_op_valid", 32'(op_valid), 0);
    chk("en0_load_ready", 32'(load_ready), 0);
    repeat (2) tick();
    en = 1; #1;
    chk("en1_op_out", 32'(op_out), 32'h0C0B);
    chk("en1_beat_idx", 32'(beat_idx), 5);
    repeat (3) tick();
    chk("en_done", 32'(done), 1);

    // Asynchronous reset mid-stream at beat 4 (vec_cnt is 1 beforehand).
    lv = 1; ld = vec_a; tick();
    lv = 0; repeat (4) tick();
    arst_n = 0; model_reset(); #1;
    chk("arst_op_valid", 32'(op_valid), 0);
    chk("arst_vec_cnt", 32'(vec_cnt), 0);
    @(posedge clk); #1 arst_n = 1; #1;
    chk("arst_load_ready", 32'(load_ready), 1);
    lv = 1; ld = vec_a; tick();
    lv = 0;
    chk("arst_restart_beat", 32'(beat_idx), 0);
    chk("arst_restart_out", 32'(op_out), 32'h0201);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_pulse();
      end else begin
        en   = ($urandom_range(0, 9) != 0);
        lv   = ($urandom_range(0, 2) == 0);
        ordy = ($urandom_range(0, 3) != 0);
        ld   = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
